// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 channel selector with out-of-range flagging and a
// dwell-timed auto-scan that walks every channel in turn.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_DIRECT | last enabled cycle was direct select (or fresh from reset)
//  ST_SCAN   | last enabled cycle was auto-scan; ptr/dwell_left are live
module mux_nto1_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 5,
    parameter int SELW  = 3,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 en,
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    output logic                 sel_err,
    output logic                 scan_wrap
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST    = SELW'(NCH - 1);
    localparam logic [SELW:0]   NCH_EXT    = (SELW + 1)'(NCH);

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic [DW-1:0]   dwell_left, dwell_left_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [SELW-1:0] out_ch_nxt;
    logic            out_valid_nxt;
    logic            sel_err_nxt;
    logic            scan_wrap_nxt;
    logic            sel_ok;

    // Compare-and-pick mux: unmatched indices fall through to zero, never X.
    function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] idx,
                                              input logic [NCH*WIDTH-1:0] bus);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == SELW'(k)) begin
                r = bus[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    assign sel_ok = ({1'b0, sel} < NCH_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_DIRECT;
            ptr        <= '0;
            dwell_left <= '0;
            out        <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            sel_err    <= 1'b0;
            scan_wrap  <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            dwell_left <= dwell_left_nxt;
            out        <= out_nxt;
            out_ch     <= out_ch_nxt;
            out_valid  <= out_valid_nxt;
            sel_err    <= sel_err_nxt;
            scan_wrap  <= scan_wrap_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        dwell_left_nxt = dwell_left;
        out_nxt        = out;
        out_ch_nxt     = out_ch;
        out_valid_nxt  = 1'b0;
        sel_err_nxt    = sel_err;
        scan_wrap_nxt  = 1'b0;

        if (en) begin
            state_nxt = mode ? ST_SCAN : ST_DIRECT;
            if (!mode) begin
                if (sel_ok) begin
                    out_nxt       = pick(sel, in_bus);
                    out_ch_nxt    = sel;
                    out_valid_nxt = 1'b1;
                    sel_err_nxt   = 1'b0;
                end else begin
                    out_nxt     = '0;
                    sel_err_nxt = 1'b1;
                end
            end else begin
                if (state == ST_DIRECT) begin
                    ptr_nxt        = sel_ok ? sel : '0;
                    dwell_left_nxt = DWELL_LAST;
                end else if (dwell_left == '0) begin
                    // Dwell expired: step to the next channel, wrapping at NCH-1.
                    dwell_left_nxt = DWELL_LAST;
                    if (ptr == CH_LAST) begin
                        ptr_nxt       = '0;
                        scan_wrap_nxt = 1'b1;
                    end else begin
                        ptr_nxt = ptr + SELW'(1);
                    end
                end else begin
                    dwell_left_nxt = dwell_left - DW'(1);
                end
                out_nxt       = pick(ptr_nxt, in_bus);
                out_ch_nxt    = ptr_nxt;
                out_valid_nxt = 1'b1;
                sel_err_nxt   = 1'b0;
            end
        end
    end

endmodule
